// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the ALU and the two-requester ALU arbiter.
//   ALU_W / ALU_CTRL_W : datapath and control-code widths
//   ALU_*              : control codes understood by alu
//   alu_req_t          : one ALU operation (operands + control)
package alu_pkg;

   localparam int ALU_W      = 32;
   localparam int ALU_CTRL_W = 4;

   localparam logic [ALU_CTRL_W-1:0] ALU_AND = 4'b0000;
   localparam logic [ALU_CTRL_W-1:0] ALU_OR  = 4'b0001;
   localparam logic [ALU_CTRL_W-1:0] ALU_ADD = 4'b0010;
   localparam logic [ALU_CTRL_W-1:0] ALU_SUB = 4'b0110;
   localparam logic [ALU_CTRL_W-1:0] ALU_SLT = 4'b0111;

   typedef struct packed {
      logic [ALU_W-1:0]      a;
      logic [ALU_W-1:0]      b;
      logic [ALU_CTRL_W-1:0] ctrl;
   } alu_req_t;

endpackage

// File: rtl/alu.sv
// alu: purely combinational 32-bit ALU.
//   a, b   : operands
//   ctrl   : control code (add, sub, and, or, unsigned slt)
//   result : operation result; unknown codes give 0
//   zero   : result == 0
module alu
   import alu_pkg::*;
(
   input  logic [ALU_W-1:0]      a,
   input  logic [ALU_W-1:0]      b,
   input  logic [ALU_CTRL_W-1:0] ctrl,
   output logic [ALU_W-1:0]      result,
   output logic                  zero
);

   always_comb begin
      result = '0;
      unique case (ctrl)
         ALU_ADD: result = a + b;
         ALU_SUB: result = a - b;
         ALU_AND: result = a & b;
         ALU_OR:  result = a | b;
         ALU_SLT: result = {{(ALU_W-1){1'b0}}, (a < b)};
         default: result = '0;
      endcase
   end

   assign zero = (result == '0);

endmodule

// File: rtl/rr_arb2.sv
// rr_arb2: two-way combinational grant logic.
//   Build option ALU_ARB_RR_EN:
//     defined   - round-robin; the requester other than the last accepted
//                 one wins contention (clk, reset, accept_i present)
//     undefined - fixed priority, requester 0 always wins contention
//   valid0_i/valid1_i : requests
//   grant0_o/grant1_o : one-hot (or zero) grant
module rr_arb2 (
`ifdef ALU_ARB_RR_EN
   input  logic clk,
   input  logic reset,
   input  logic accept_i,
`endif
   input  logic valid0_i,
   input  logic valid1_i,
   output logic grant0_o,
   output logic grant1_o
);

`ifdef ALU_ARB_RR_EN
   // Resets to 1 so requester 0 wins the first contention.
   logic last_q;
   logic last_d;

   assign grant0_o = valid0_i & (~valid1_i | last_q);
   assign grant1_o = valid1_i & (~valid0_i | ~last_q);

   assign last_d = accept_i ? grant1_o : last_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) last_q <= 1'b1;
      else       last_q <= last_d;
   end
`else
   assign grant0_o = valid0_i;
   assign grant1_o = valid1_i & ~valid0_i;
`endif

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one ALU between two valid/ready requesters and holds
// the result in a one-entry output stage with its own valid/ready.
//   Build option ALU_ARB_RR_EN selects round-robin (defined) or fixed
//   priority to requester 0 (undefined).
//   clk, reset            : clock, async active-high reset
//   reqN_valid/ready      : requester N handshake
//   reqN_a/b/ctrl         : requester N operation
//   rsp_valid/ready       : output stage handshake
//   rsp_id/result/zero    : issuing requester, result, result == 0
//   op_count              : accepted operations, wraps at 16 bits
module alu_arbiter
   import alu_pkg::*;
(
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req0_valid,
   output logic                  req0_ready,
   input  logic [ALU_W-1:0]      req0_a,
   input  logic [ALU_W-1:0]      req0_b,
   input  logic [ALU_CTRL_W-1:0] req0_ctrl,
   input  logic                  req1_valid,
   output logic                  req1_ready,
   input  logic [ALU_W-1:0]      req1_a,
   input  logic [ALU_W-1:0]      req1_b,
   input  logic [ALU_CTRL_W-1:0] req1_ctrl,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic                  rsp_id,
   output logic [ALU_W-1:0]      rsp_result,
   output logic                  rsp_zero,
   output logic [15:0]           op_count
);

   logic             grant0, grant1;
   logic             stage_free;
   logic             accept;
   alu_req_t         sel_req;
   logic [ALU_W-1:0] alu_result;
   logic             alu_zero;

   logic             rsp_valid_q,  rsp_valid_d;
   logic             rsp_id_q,     rsp_id_d;
   logic [ALU_W-1:0] rsp_result_q, rsp_result_d;
   logic             rsp_zero_q,   rsp_zero_d;
   logic [15:0]      op_count_q,   op_count_d;

   rr_arb2 u_arb (
`ifdef ALU_ARB_RR_EN
      .clk      (clk),
      .reset    (reset),
      .accept_i (accept),
`endif
      .valid0_i (req0_valid),
      .valid1_i (req1_valid),
      .grant0_o (grant0),
      .grant1_o (grant1)
   );

   assign stage_free = ~rsp_valid_q | rsp_ready;
   assign req0_ready = grant0 & stage_free;
   assign req1_ready = grant1 & stage_free;
   assign accept     = (req0_valid & req0_ready) | (req1_valid & req1_ready);

   always_comb begin
      if (grant1) sel_req = '{a: req1_a, b: req1_b, ctrl: req1_ctrl};
      else        sel_req = '{a: req0_a, b: req0_b, ctrl: req0_ctrl};
   end

   alu u_alu (
      .a      (sel_req.a),
      .b      (sel_req.b),
      .ctrl   (sel_req.ctrl),
      .result (alu_result),
      .zero   (alu_zero)
   );

   // Payload registers only change on accept; an idle free stage just drops valid.
   always_comb begin
      rsp_valid_d  = rsp_valid_q;
      rsp_id_d     = rsp_id_q;
      rsp_result_d = rsp_result_q;
      rsp_zero_d   = rsp_zero_q;
      op_count_d   = op_count_q;
      if (accept) begin
         rsp_valid_d  = 1'b1;
         rsp_id_d     = grant1;
         rsp_result_d = alu_result;
         rsp_zero_d   = alu_zero;
         op_count_d   = op_count_q + 16'd1;
      end else if (stage_free) begin
         rsp_valid_d  = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rsp_valid_q  <= 1'b0;
         rsp_id_q     <= 1'b0;
         rsp_result_q <= '0;
         rsp_zero_q   <= 1'b0;
         op_count_q   <= '0;
      end else begin
         rsp_valid_q  <= rsp_valid_d;
         rsp_id_q     <= rsp_id_d;
         rsp_result_q <= rsp_result_d;
         rsp_zero_q   <= rsp_zero_d;
         op_count_q   <= op_count_d;
      end
   end

   assign rsp_valid  = rsp_valid_q;
   assign rsp_id     = rsp_id_q;
   assign rsp_result = rsp_result_q;
   assign rsp_zero   = rsp_zero_q;
   assign op_count   = op_count_q;

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;
   import alu_pkg::*;

`ifdef ALU_ARB_RR_EN
   localparam bit RR_MODE = 1'b1;
`else
   localparam bit RR_MODE = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic        req0_valid, req0_ready;
   logic [31:0] req0_a, req0_b;
   logic [3:0]  req0_ctrl;
   logic        req1_valid, req1_ready;
   logic [31:0] req1_a, req1_b;
   logic [3:0]  req1_ctrl;
   logic        rsp_valid, rsp_ready, rsp_id, rsp_zero;
   logic [31:0] rsp_result;
   logic [15:0] op_count;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   alu_arbiter dut (
      .clk        (clk),
      .reset      (reset),
      .req0_valid (req0_valid),
      .req0_ready (req0_ready),
      .req0_a     (req0_a),
      .req0_b     (req0_b),
      .req0_ctrl  (req0_ctrl),
      .req1_valid (req1_valid),
      .req1_ready (req1_ready),
      .req1_a     (req1_a),
      .req1_b     (req1_b),
      .req1_ctrl  (req1_ctrl),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_id     (rsp_id),
      .rsp_result (rsp_result),
      .rsp_zero   (rsp_zero),
      .op_count   (op_count)
   );

   typedef struct {
      logic        v0;
      logic [31:0] a0, b0;
      logic [3:0]  c0;
      logic        v1;
      logic [31:0] a1, b1;
      logic [3:0]  c1;
      logic        rr;
      logic        e_rdy0, e_rdy1, e_valid, e_id;
      logic [31:0] e_res;
      logic        e_zero;
      logic [15:0] e_cnt;
      logic        chk_data;
   } vec_t;

   localparam int NVEC = 11;
   vec_t vecs [NVEC];

   function automatic vec_t mk(
      input logic v0, input logic [31:0] a0, input logic [31:0] b0, input logic [3:0] c0,
      input logic v1, input logic [31:0] a1, input logic [31:0] b1, input logic [3:0] c1,
      input logic rr, input logic e_rdy0, input logic e_rdy1, input logic e_valid,
      input logic e_id, input logic [31:0] e_res, input logic e_zero,
      input logic [15:0] e_cnt, input logic chk_data);
      vec_t v;
      v.v0 = v0; v.a0 = a0; v.b0 = b0; v.c0 = c0;
      v.v1 = v1; v.a1 = a1; v.b1 = b1; v.c1 = c1;
      v.rr = rr; v.e_rdy0 = e_rdy0; v.e_rdy1 = e_rdy1; v.e_valid = e_valid;
      v.e_id = e_id; v.e_res = e_res; v.e_zero = e_zero; v.e_cnt = e_cnt;
      v.chk_data = chk_data;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      req0_valid = v.v0; req0_a = v.a0; req0_b = v.b0; req0_ctrl = v.c0;
      req1_valid = v.v1; req1_a = v.a1; req1_b = v.b1; req1_ctrl = v.c1;
      rsp_ready  = v.rr;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_rsp(input string tag, input logic e_valid, input logic e_id,
                            input logic [31:0] e_res, input logic e_zero, input logic [15:0] e_cnt);
      check({tag, " rsp_valid"},  32'(rsp_valid),  32'(e_valid));
      check({tag, " rsp_id"},     32'(rsp_id),     32'(e_id));
      check({tag, " rsp_result"}, rsp_result,      e_res);
      check({tag, " rsp_zero"},   32'(rsp_zero),   32'(e_zero));
      check({tag, " op_count"},   32'(op_count),   32'(e_cnt));
   endtask

   initial begin
      logic cid;
      // Table: contention first so the round-robin sequence starts from reset.
      vecs[0] = mk(0, 0, 0, ALU_ADD, 0, 0, 0, ALU_ADD, 1, 0, 0, 0, 0, 32'd0, 0, 16'd0, 1);
      for (int k = 0; k < 4; k++) begin
         cid = RR_MODE ? k[0] : 1'b0;
         vecs[1+k] = mk(1, 32'd9, 32'd9, ALU_SUB, 1, 32'd3, 32'hFFFF_FFFF, ALU_SLT, 1,
                        ~cid, cid, 1, cid, cid ? 32'd1 : 32'd0, ~cid, 16'(k + 1), 1);
      end
      vecs[5]  = mk(1, 32'd5, 32'd7, ALU_ADD, 0, 0, 0, ALU_ADD, 1, 1, 0, 1, 0, 32'd12, 0, 16'd5, 1);
      vecs[6]  = mk(0, 0, 0, ALU_ADD, 1, 32'd3, 32'd5, ALU_SUB, 1, 0, 1, 1, 1, 32'hFFFF_FFFE, 0, 16'd6, 1);
      vecs[7]  = mk(1, 32'd5, 32'd5, 4'b1111, 0, 0, 0, ALU_ADD, 1, 1, 0, 1, 0, 32'd0, 1, 16'd7, 1);
      vecs[8]  = mk(1, 32'd7, 32'd3, ALU_SLT, 0, 0, 0, ALU_ADD, 1, 1, 0, 1, 0, 32'd0, 1, 16'd8, 1);
      vecs[9]  = mk(0, 0, 0, ALU_ADD, 1, 32'd3, 32'd7, ALU_SLT, 1, 0, 1, 1, 1, 32'd1, 0, 16'd9, 1);
      vecs[10] = mk(0, 0, 0, ALU_ADD, 0, 0, 0, ALU_ADD, 1, 0, 0, 0, 0, 32'd0, 0, 16'd9, 0);

      // Reset and idle.
      reset = 1'b1;
      drive(vecs[0]);
      rsp_ready = 1'b0;
      tick(); tick();
      reset = 1'b0;
      #1;
      check("reset req0_ready", 32'(req0_ready), 32'd0);
      check("reset req1_ready", 32'(req1_ready), 32'd0);
      check_rsp("reset", 0, 0, 32'd0, 0, 16'd0);

      for (int i = 0; i < NVEC; i++) begin
         drive(vecs[i]);
         #1;
         check($sformatf("v%0d req0_ready", i), 32'(req0_ready), 32'(vecs[i].e_rdy0));
         check($sformatf("v%0d req1_ready", i), 32'(req1_ready), 32'(vecs[i].e_rdy1));
         tick();
         check($sformatf("v%0d rsp_valid", i), 32'(rsp_valid), 32'(vecs[i].e_valid));
         check($sformatf("v%0d op_count", i),  32'(op_count),  32'(vecs[i].e_cnt));
         if (vecs[i].chk_data) begin
            check($sformatf("v%0d rsp_id", i),     32'(rsp_id),   32'(vecs[i].e_id));
            check($sformatf("v%0d rsp_result", i), rsp_result,    vecs[i].e_res);
            check($sformatf("v%0d rsp_zero", i),   32'(rsp_zero), 32'(vecs[i].e_zero));
         end
      end

      // Backpressure: load a result, then hold it for 3 cycles.
      req0_valid = 1; req0_a = 32'd1; req0_b = 32'd1; req0_ctrl = ALU_ADD;
      req1_valid = 0; rsp_ready = 1;
      tick();
      check_rsp("bp load", 1, 0, 32'd2, 0, 16'd10);
      rsp_ready = 0;
      req0_a = 32'd4; req0_b = 32'd4;
      req1_valid = 1; req1_a = 32'hFF; req1_b = 32'h0F; req1_ctrl = ALU_AND;
      for (int k = 0; k < 3; k++) begin
         #1;
         check($sformatf("bp%0d req0_ready", k), 32'(req0_ready), 32'd0);
         check($sformatf("bp%0d req1_ready", k), 32'(req1_ready), 32'd0);
         tick();
         check_rsp($sformatf("bp%0d hold", k), 1, 0, 32'd2, 0, 16'd10);
      end
      // Drain and accept in the same cycle.
      rsp_ready = 1; req0_valid = 0;
      #1;
      check("drain req1_ready", 32'(req1_ready), 32'd1);
      check("drain req0_ready", 32'(req0_ready), 32'd0);
      tick();
      check_rsp("drain accept", 1, 1, 32'h0F, 0, 16'd11);

      // Reset mid-operation discards the held result at once.
      req1_valid = 0; rsp_ready = 0;
      #2;
      reset = 1'b1;
      #1;
      check_rsp("midreset", 0, 0, 32'd0, 0, 16'd0);
      tick();
      reset = 1'b0;
      req0_valid = 1; req0_a = 32'd2; req0_b = 32'd3; req0_ctrl = ALU_ADD;
      req1_valid = 1; req1_a = 32'd1; req1_b = 32'd2; req1_ctrl = ALU_OR;
      rsp_ready = 1;
      #1;
      check("postreset req0_ready", 32'(req0_ready), 32'd1);
      check("postreset req1_ready", 32'(req1_ready), 32'd0);
      tick();
      check_rsp("postreset", 1, 0, 32'd5, 0, 16'd1);

      // op_count wrap: 65534 more accepts reach 0xFFFF, one more wraps.
      req1_valid = 0;
      req0_a = 32'd0; req0_b = 32'd0;
      for (int k = 0; k < 65534; k++) tick();
      check("wrap pre op_count", 32'(op_count), 32'h0000_FFFF);
      tick();
      check_rsp("wrap", 1, 0, 32'd0, 1, 16'd0);

      req0_valid = 0;
      tick();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
